// File: rtl/md6_pkg.sv
// md6_pkg: shared constants for the MD6 compression engine.
//   W/NW/CW       : word width, words in N, words in C
//   T0..T5        : feedback tap distances (A[i-T])
//   RS_TAB/LS_TAB : per-step right/left shift amounts, indexed by step mod 16
//   S0/S_STAR     : round-constant seed and its update mask
//   V_WORD/V_R_*  : location of the round count r inside the V control word
//   ST_*          : FSM state encodings
// Optional build macro referenced by users of this package: MD6_CORE_TWO_STEP_EN.
package md6_pkg;

  localparam int W  = 64;
  localparam int NW = 89;
  localparam int CW = 16;

  localparam int T0 = 17;
  localparam int T1 = 18;
  localparam int T2 = 21;
  localparam int T3 = 31;
  localparam int T4 = 67;
  localparam int T5 = 89;

  localparam logic [5:0] RS_TAB [16] = '{6'd10, 6'd5, 6'd13, 6'd10, 6'd11, 6'd12, 6'd2, 6'd7,
                                         6'd14, 6'd15, 6'd7, 6'd13, 6'd11, 6'd7, 6'd6, 6'd12};
  localparam logic [5:0] LS_TAB [16] = '{6'd11, 6'd24, 6'd9, 6'd16, 6'd15, 6'd9, 6'd27, 6'd15,
                                         6'd6, 6'd2, 6'd29, 6'd8, 6'd15, 6'd5, 6'd31, 6'd9};

  localparam logic [W-1:0] S0     = 64'h0123456789abcdef;
  localparam logic [W-1:0] S_STAR = 64'h7311c2812425cfa0;

  localparam int V_WORD = 24;
  localparam int V_R_LO = 48;
  localparam int V_R_HI = 59;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Round-constant advance applied once every 16 steps.
  function automatic logic [W-1:0] s_next(input logic [W-1:0] s);
    return {s[W-2:0], s[W-1]} ^ (s & S_STAR);
  endfunction

endpackage

// File: rtl/md6_compress_core_if.sv
// md6_compress_core_if: handshake bundle between an N producer and the core.
//   in_valid/in_ready/n_in    : N block offer and acceptance
//   out_valid/out_ready/c_out : chaining value hand-off
//   busy                      : compute in progress
// slave modport is the core side, master the producer/consumer side.
import md6_pkg::*;

interface md6_compress_core_if;
  logic              in_valid;
  logic              in_ready;
  logic [NW*W-1:0]   n_in;
  logic              out_valid;
  logic              out_ready;
  logic [CW*W-1:0]   c_out;
  logic              busy;

  modport slave  (input  in_valid, n_in, out_ready,
                  output in_ready, out_valid, c_out, busy);
  modport master (output in_valid, n_in, out_ready,
                  input  in_ready, out_valid, c_out, busy);
endinterface

// File: rtl/md6_step.sv
// md6_step: one combinational MD6 feedback step.
//   a_n  : A[i-89]     a_t0..a_t4 : A[i-17], A[i-18], A[i-21], A[i-31], A[i-67]
//   s    : current round constant   idx : step mod 16 (shift-table index)
//   x    : new word A[i]
import md6_pkg::*;

module md6_step (
  input  logic [W-1:0] a_n,
  input  logic [W-1:0] a_t0,
  input  logic [W-1:0] a_t1,
  input  logic [W-1:0] a_t2,
  input  logic [W-1:0] a_t3,
  input  logic [W-1:0] a_t4,
  input  logic [W-1:0] s,
  input  logic [3:0]   idx,
  output logic [W-1:0] x
);

  logic [W-1:0] mix;
  logic [W-1:0] rsh;

  always_comb begin
    mix = s ^ a_n ^ a_t0 ^ (a_t1 & a_t2) ^ (a_t3 & a_t4);
    rsh = mix ^ (mix >> RS_TAB[idx]);
    x   = rsh ^ (rsh << LS_TAB[idx]);
  end

endmodule

// File: rtl/md6_compress_core.sv
// md6_compress_core: iterative MD6 compression engine.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : md6_compress_core_if.slave (N in, C out, busy)
// An 89-word shift register holds the last 89 A words; each RUN step
// shifts in one new word. After 16*r steps the top 16 words are C.
// Build option MD6_CORE_TWO_STEP_EN: two steps per cycle (all taps are at
// least 17 words back, so the second step never needs the first's result).
import md6_pkg::*;

module md6_compress_core (
  input  logic                 clk,
  input  logic                 rst_n,
  md6_compress_core_if.slave   bus
);

  logic [1:0]   state_q, state_d;
  logic [11:0]  r_q, r_d;
  logic [W-1:0] s_q, s_d;
  logic [15:0]  step_q, step_d;
  logic [W-1:0] reg_q [NW];
  logic [W-1:0] reg_d [NW];

  logic [W-1:0] x0;
  logic         last_step;
  logic         s_boundary;

  md6_step u_step0 (
    .a_n (reg_q[NW-T5]), .a_t0(reg_q[NW-T0]), .a_t1(reg_q[NW-T1]),
    .a_t2(reg_q[NW-T2]), .a_t3(reg_q[NW-T3]), .a_t4(reg_q[NW-T4]),
    .s(s_q), .idx(step_q[3:0]), .x(x0)
  );

`ifdef MD6_CORE_TWO_STEP_EN
  logic [W-1:0] x1;
  logic [3:0]   idx1;

  assign idx1 = step_q[3:0] + 4'd1;

  // Second step reads every tap one word further along the register.
  md6_step u_step1 (
    .a_n (reg_q[NW-T5+1]), .a_t0(reg_q[NW-T0+1]), .a_t1(reg_q[NW-T1+1]),
    .a_t2(reg_q[NW-T2+1]), .a_t3(reg_q[NW-T3+1]), .a_t4(reg_q[NW-T4+1]),
    .s(s_q), .idx(idx1), .x(x1)
  );

  assign last_step  = (step_q == {r_q - 12'd1, 4'he});
  assign s_boundary = (step_q[3:0] == 4'he);
`else
  assign last_step  = (step_q == {r_q - 12'd1, 4'hf});
  assign s_boundary = (step_q[3:0] == 4'hf);
`endif

  // Next-state logic: load in IDLE, shift/compute in RUN, wait in HOLD.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s_d     = s_q;
    step_d  = step_q;
    for (int k = 0; k < NW; k++) reg_d[k] = reg_q[k];

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          for (int k = 0; k < NW; k++) reg_d[k] = bus.n_in[k*W +: W];
          r_d     = bus.n_in[V_WORD*W+V_R_HI : V_WORD*W+V_R_LO];
          s_d     = S0;
          step_d  = '0;
          state_d = (r_d == 12'd0) ? ST_HOLD : ST_RUN;
        end
      end
      ST_RUN: begin
`ifdef MD6_CORE_TWO_STEP_EN
        for (int k = 0; k < NW-2; k++) reg_d[k] = reg_q[k+2];
        reg_d[NW-2] = x0;
        reg_d[NW-1] = x1;
        step_d      = step_q + 16'd2;
`else
        for (int k = 0; k < NW-1; k++) reg_d[k] = reg_q[k+1];
        reg_d[NW-1] = x0;
        step_d      = step_q + 16'd1;
`endif
        if (s_boundary) s_d = s_next(s_q);
        if (last_step) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      s_q     <= '0;
      step_q  <= '0;
      for (int k = 0; k < NW; k++) reg_q[k] <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      step_q  <= step_d;
      for (int k = 0; k < NW; k++) reg_q[k] <= reg_d[k];
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.busy      = (state_q == ST_RUN);

  // C is gated to zero outside HOLD so partial state is never exposed.
  always_comb begin
    bus.c_out = '0;
    if (state_q == ST_HOLD) begin
      for (int j = 0; j < CW; j++) bus.c_out[j*W +: W] = reg_q[NW-CW+j];
    end
  end

endmodule

// File: tb/tb_md6_compress_core.sv
// tb_md6_compress_core: directed self-checking bench for md6_compress_core.
// Expected C values come from a straightforward array-form MD6 model and
// are queued when a block is offered, then popped when the core presents C.
// Honours MD6_CORE_TWO_STEP_EN for the expected latency.
module tb_md6_compress_core;

  localparam int TW  = 64;
  localparam int TNW = 89;
  localparam int TCW = 16;
`ifdef MD6_CORE_TWO_STEP_EN
  localparam int STEPS_PER_CYC = 2;
`else
  localparam int STEPS_PER_CYC = 1;
`endif

  logic clk;
  logic rst_n;

  md6_compress_core_if bus ();

  md6_compress_core dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int lat_cnt;

  logic [TCW*TW-1:0] exp_q [$];
  logic [TW-1:0]     ga [0:TNW+16*64-1];

  int tb_rs [16] = '{10, 5, 13, 10, 11, 12, 2, 7, 14, 15, 7, 13, 11, 7, 6, 12};
  int tb_ls [16] = '{11, 24, 9, 16, 15, 9, 27, 15, 6, 2, 29, 8, 15, 5, 31, 9};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [TNW*TW-1:0] makeBlock(input int r);
    logic [TNW*TW-1:0] b;
    for (int k = 0; k < TNW; k++) b[k*TW +: TW] = {$urandom(), $urandom()};
    b[24*TW+48 +: 12] = r[11:0];
    return b;
  endfunction

  // Reference: A[i] computed in place over a flat array, S per 16-step round.
  task computeGolden(input logic [TNW*TW-1:0] n, output logic [TCW*TW-1:0] c);
    logic [TW-1:0] s;
    logic [TW-1:0] x;
    int r;
    int t;
    int st;
    r = int'(n[24*TW+48 +: 12]);
    t = 16 * r;
    for (int i = 0; i < TNW; i++) ga[i] = n[i*TW +: TW];
    s = 64'h0123456789abcdef;
    for (int i = TNW; i < TNW + t; i++) begin
      st = i - TNW;
      x = s ^ ga[i-89] ^ ga[i-17] ^ (ga[i-18] & ga[i-21]) ^ (ga[i-31] & ga[i-67]);
      x = x ^ (x >> tb_rs[st % 16]);
      x = x ^ (x << tb_ls[st % 16]);
      ga[i] = x;
      if (st % 16 == 15) s = {s[62:0], s[63]} ^ (s & 64'h7311c2812425cfa0);
    end
    for (int j = 0; j < TCW; j++) c[j*TW +: TW] = ga[t + 73 + j];
  endtask

  task pushExpected(input logic [TNW*TW-1:0] n);
    logic [TCW*TW-1:0] c;
    computeGolden(n, c);
    exp_q.push_back(c);
  endtask

  // Offer a block from a negedge; returns at the negedge after the accept edge.
  task applyStimulus(input logic [TNW*TW-1:0] n, input bit hold_valid);
    bus.n_in     = n;
    bus.in_valid = 1'b1;
    pushExpected(n);
    @(negedge clk);
    lat_cnt = 1;
    if (!hold_valid) bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then check latency and C against the queue.
  task checkOutput(input int exp_lat, input string tag);
    logic [TCW*TW-1:0] expc;
    while (!bus.out_valid && lat_cnt < 3000) begin
      @(negedge clk);
      lat_cnt++;
    end
    checkVal({tag, "_latency"}, 64'(lat_cnt), 64'(exp_lat));
    checkVal({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    checkVal({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_scoreboard: observed=empty expected=entry", tag);
    end else begin
      expc = exp_q.pop_front();
      for (int j = 0; j < TCW; j++)
        checkVal($sformatf("%s_c%0d", tag, j), bus.c_out[j*TW +: TW], expc[j*TW +: TW]);
    end
  endtask

  task finishHandshake(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkVal({tag, "_idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    checkVal({tag, "_idle_out_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [TNW*TW-1:0] n;
    logic [TNW*TW-1:0] n2;
    logic [TCW*TW-1:0] snap;
    bit seen;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.n_in      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    checkVal("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkVal("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("rst_busy", 64'(bus.busy), 64'd0);
    checkVal("rst_c_out_zero", 64'(bus.c_out != '0), 64'd0);

    // r = 0 pass-through: B words 48..63 (N words 73..88) = 1..16
    n = makeBlock(0);
    for (int j = 0; j < TCW; j++) n[(73+j)*TW +: TW] = 64'(j + 1);
    applyStimulus(n, 1'b0);
    checkVal("pass_c0_const", bus.c_out[0 +: TW], 64'd1);
    checkVal("pass_c15_const", bus.c_out[15*TW +: TW], 64'd16);
    checkOutput(1, "pass");
    finishHandshake("pass");

    // r = 5 random block, then back-pressure in HOLD
    n = makeBlock(5);
    applyStimulus(n, 1'b0);
    checkVal("r5_busy", 64'(bus.busy), 64'd1);
    checkVal("r5_in_ready_low", 64'(bus.in_ready), 64'd0);
    checkOutput(16*5/STEPS_PER_CYC + 1, "r5");
    snap = bus.c_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkVal($sformatf("hold_stable_%0d", i), 64'(bus.c_out !== snap), 64'd0);
      checkVal($sformatf("hold_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
    end
    finishHandshake("hold");

    // Reset during a run: no C, core back in IDLE
    n = makeBlock(5);
    applyStimulus(n, 1'b0);
    repeat (37) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    checkVal("abort_in_ready", 64'(bus.in_ready), 64'd1);
    checkVal("abort_busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      seen = seen | bus.out_valid;
      @(negedge clk);
    end
    checkVal("abort_no_out_valid", 64'(seen), 64'd0);
    n = makeBlock(5);
    applyStimulus(n, 1'b0);
    checkOutput(16*5/STEPS_PER_CYC + 1, "post_abort");
    finishHandshake("post_abort");

    // Back-to-back r=1 then r=40 with in_valid held high
    bus.out_ready = 1'b1;
    n  = makeBlock(1);
    n2 = makeBlock(40);
    applyStimulus(n, 1'b1);
    bus.n_in = n2;
    pushExpected(n2);
    checkOutput(16*1/STEPS_PER_CYC + 1, "b2b_first");
    @(negedge clk);
    checkVal("b2b_idle_between", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    lat_cnt = 1;
    bus.in_valid = 1'b0;
    checkVal("b2b_second_busy", 64'(bus.busy), 64'd1);
    checkOutput(16*40/STEPS_PER_CYC + 1, "b2b_second");
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkVal("b2b_end_in_ready", 64'(bus.in_ready), 64'd1);
    checkVal("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md6_compress_core.md
Name: md6_compress_core

Overview:
- Iterative MD6 compression engine. It consumes the 89-word N block produced by the N-assembly logic (Q, K, U, V, B) and runs t = 16·r feedback steps.
- It returns the 16-word chaining value C, which goes to the next tree level or to final hash truncation.
- It is the reader of the N vector. The round count r is decoded from the V control word inside N.

Parameters:
- W, 64, word width in bits. Only 64 is supported.
- NW, 89, words in N.
- CW, 16, words in C.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, N block offered.
- in_ready, output, 1, core idle and able to accept N.
- n_in, input, NW·W, N vector. Word k occupies bits [(k+1)·W-1 : k·W]. Word 0 is Q[0]. Word 24 is V.
- out_valid, output, 1, C held valid.
- out_ready, input, 1, downstream accepts C.
- c_out, output, CW·W, chaining value. Word j is A[t+73+j] in MD6 numbering.
- busy, output, 1, compute in progress.

Behaviour:
- Reset: all outputs are 0 except in_ready. in_ready is 1 on the first cycle after reset is released. The shift register, step counter and S register are cleared. Reset mid-compute aborts the run; no C is emitted.
- FSM states: IDLE, RUN, HOLD.
- IDLE: in_ready=1. On in_valid:
  - load reg[k] ← n_in word k for k = 0..88;
  - R ← n_in[24·W+59 : 24·W+48];
  - S ← 0x0123456789abcdef;
  - step ← 0.
  - If R = 0, go to HOLD; otherwise go to RUN.
- RUN: one step per cycle. reg[k] holds A[i-89+k].
  - x = S ^ reg[0] ^ reg[72] ^ (reg[71] & reg[68]) ^ (reg[58] & reg[22]).
  - x ^= x >> rs[step mod 16]; then x ^= x << ls[step mod 16].
  - Shift: reg[k] ← reg[k+1]; reg[88] ← x.
  - rs table, index 0..15: 10,5,13,10,11,12,2,7,14,15,7,13,11,7,6,12.
  - ls table, index 0..15: 11,24,9,16,15,9,27,15,6,2,29,8,15,5,31,9.
  - When step mod 16 = 15, update S ← (S rotated left by 1) ^ (S & 0x7311c2812425cfa0).
  - After the step with step = 16·R−1, go to HOLD.
  - The step counter is 16 bits wide (R ≤ 4095), so it never wraps.
- HOLD: out_valid=1 and c_out[j] = reg[73+j]. c_out is stable while out_valid=1 and out_ready=0. The transfer completes on out_valid & out_ready, after which the FSM returns to IDLE.
- in_ready is 0 in RUN and HOLD. A new block is accepted at the earliest on the cycle after the handshake.
- Latency: the load-accept cycle is followed by 16·R RUN cycles. out_valid rises on the next edge after the last RUN cycle.
- R = 0: pass-through; C equals N words 73..88, with out_valid one cycle after accept.
- busy=1 exactly in RUN.
- in_valid while not in IDLE is ignored, with no side effect.

Optional Feature:
- MD6_CORE_TWO_STEP_EN defined: two steps per cycle. This is legal because the smallest tap distance is 17.
  - The second step uses the taps shifted by one and table index step+1.
  - The shift is by two words; step increments by 2.
  - RUN lasts 8·R cycles.
  - S still updates only at 16-step boundaries; step pairs never straddle a boundary.
- Undefined: one step per cycle, as above.
- c_out is identical in both builds.

Decomposition:
- Shared package md6_pkg holds:
  - W, NW, CW;
  - tap constants 17, 18, 21, 31, 67, 89;
  - the rs/ls tables as 16-entry constant arrays;
  - S0 and S_STAR;
  - the V bit-field positions (r at 59:48);
  - the FSM state enum.
- One sub-module, md6_step, holds the combinational single step: inputs are the five tap words, S and table index; output is the new word. It is instantiated once normally and twice under MD6_CORE_TWO_STEP_EN.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, busy=0, c_out=0.
- N with V.r=0 and B words 48..63 = 1..16 → one cycle after accept, out_valid=1 and c_out words = 1..16.
- N with V.r=5 and random K/U/B → out_valid exactly 81 clocks after the accept edge (41 with MD6_CORE_TWO_STEP_EN); c_out matches the md6_compress C golden model.
- out_ready held 0 for 10 cycles in HOLD → c_out stable and in_ready=0; after out_ready=1 for 1 cycle, in_ready=1.
- rst_n pulled low at step 37 of an r=5 run → next cycle in IDLE, out_valid never asserted; a subsequent block produces the correct result.
- Back-to-back blocks with r=1 and r=40 (d=0 convention), in_valid held high → each accepted only in IDLE; both results match the golden model in order.
